// File: rtl/tx_iq_streamer.sv
// tx_iq_streamer: drains the TX IQ FIFO to the DAC, one sample per strobe, with prime, underrun and zero tail (option TX_IQ_STREAMER_HOLD_LAST_EN)
module tx_iq_streamer #(
    parameter int IQ_WIDTH   = 32,
    parameter int CNT_WIDTH  = 10,
    parameter int TAIL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_strobe,
    input  logic                  phy_tx_started,
    input  logic                  phy_tx_done,
    input  logic [CNT_WIDTH-1:0]  start_threshold,
    input  logic [TAIL_WIDTH-1:0] tail_len,
    input  logic                  tx_iq_fifo_empty,
    input  logic [CNT_WIDTH-1:0]  tx_iq_fifo_data_count,
    input  logic [IQ_WIDTH-1:0]   tx_iq_fifo_dout,
    output logic                  tx_iq_fifo_rden,
    output logic [IQ_WIDTH-1:0]   dac_iq,
    output logic                  dac_iq_valid,
    output logic                  tx_stream_active,
    output logic                  pulse_underrun,
    output logic                  pulse_stream_end,
    output logic [15:0]           underrun_count
);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, TAIL} state_t;
    state_t state, state_n;
    logic [TAIL_WIDTH-1:0] tail_cnt, tail_n;
    logic [IQ_WIDTH-1:0] under_val;
    logic done_seen, done_now, pop, und, tail_out, end_n;
    always_comb begin
        state_n  = state;
        tail_n   = tail_cnt;
        pop      = 1'b0;
        und      = 1'b0;
        tail_out = 1'b0;
        end_n    = 1'b0;
        done_now = done_seen | phy_tx_done;
        case (state)
            IDLE:   state_n = phy_tx_started ? PRIME : IDLE;
            PRIME:  state_n = (!tx_iq_fifo_empty && (tx_iq_fifo_data_count >= start_threshold || done_now)) ? STREAM :
                              done_now ? IDLE : PRIME;
            STREAM: if (sample_strobe) begin
                pop = !tx_iq_fifo_empty;
                und = tx_iq_fifo_empty && !done_now;
                if (tx_iq_fifo_empty && done_now) begin
                    end_n   = tail_len == '0;
                    state_n = (tail_len == '0) ? IDLE : TAIL;
                    tail_n  = tail_len;
                end
            end
            default: if (sample_strobe) begin
                tail_out = 1'b1;
                tail_n   = tail_cnt - 1'b1;
                end_n    = tail_cnt == TAIL_WIDTH'(1);
                state_n  = (tail_cnt == TAIL_WIDTH'(1)) ? IDLE : TAIL;
            end
        endcase
    end
    assign tx_iq_fifo_rden  = pop & ~rst;
    assign tx_stream_active = state != IDLE;
`ifdef TX_IQ_STREAMER_HOLD_LAST_EN
    logic [IQ_WIDTH-1:0] last_q;
    always_ff @(posedge clk) begin
        if (rst || state_n == IDLE) last_q <= '0;
        else if (pop) last_q <= tx_iq_fifo_dout;
    end
    assign under_val = last_q;
`else
    assign under_val = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tail_cnt         <= '0;
            done_seen        <= 1'b0;
            dac_iq           <= '0;
            dac_iq_valid     <= 1'b0;
            pulse_underrun   <= 1'b0;
            pulse_stream_end <= 1'b0;
            underrun_count   <= '0;
        end else begin
            state            <= state_n;
            tail_cnt         <= tail_n;
            done_seen        <= (state_n == IDLE) ? 1'b0 : done_seen | (phy_tx_done & (state != IDLE));
            dac_iq           <= pop ? tx_iq_fifo_dout : und ? under_val : '0;
            dac_iq_valid     <= pop | und | tail_out;
            pulse_underrun   <= und;
            pulse_stream_end <= end_n;
            if (und && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end
    end
endmodule

// File: doc/tx_iq_streamer.md
Name: tx_iq_streamer

Overview:
- Read side of the TX IQ FIFO; the PHY writes the FIFO, this block drains it.
- Drains one IQ sample per DAC sample strobe, and only starts once enough samples are buffered, to avoid a mid-packet underrun.
- After the PHY finishes, it drains the remainder and appends a zero tail before going idle.
- Sits between the FIFO and the DAC interface. Provides stream status and underrun statistics to xpu/tx_control.

Parameters:
- IQ_WIDTH, 32, width of one packed I/Q sample.
- CNT_WIDTH, 10, width of the FIFO data count and of start_threshold.
- TAIL_WIDTH, 8, width of tail_len.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- sample_strobe  input  1  one-cycle DAC sample tick.
- phy_tx_started  input  1  one-cycle pulse: PHY began writing a packet.
- phy_tx_done  input  1  one-cycle pulse: PHY wrote the last sample.
- start_threshold  input  CNT_WIDTH  minimum buffered samples before streaming begins.
- tail_len  input  TAIL_WIDTH  number of zero samples appended after the last real sample.
- tx_iq_fifo_empty  input  1  FIFO empty flag.
- tx_iq_fifo_data_count  input  CNT_WIDTH  FIFO occupancy.
- tx_iq_fifo_dout  input  IQ_WIDTH  FIFO head word. The FIFO is first-word-fall-through: dout is valid whenever not empty.
- tx_iq_fifo_rden  output  1  pop strobe.
- dac_iq  output  IQ_WIDTH  registered sample to the DAC.
- dac_iq_valid  output  1  one-cycle qualifier for dac_iq.
- tx_stream_active  output  1  high in PRIME, STREAM and TAIL.
- pulse_underrun  output  1  one-cycle pulse per underrun sample.
- pulse_stream_end  output  1  one-cycle pulse on the TAIL/STREAM to IDLE transition.
- underrun_count  output  16  saturating underrun counter; cleared only by rst.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including dac_iq, underrun_count and rden. done_seen=0.
- rst has priority over every other input in the same cycle.
- tx_iq_fifo_rden is combinational: sample_strobe & state==STREAM & !tx_iq_fifo_empty. It is never asserted while rst=1.
- Output latency: on a strobe in cycle T, dac_iq and dac_iq_valid update at T+1.
  - Popped sample: dac_iq = dout from cycle T.
  - Underrun sample or tail sample: dac_iq = 0.
  - Strobes in IDLE or PRIME: no dac_iq_valid, and dac_iq holds 0.
- done_seen: set by phy_tx_done in any non-IDLE state; cleared on entry to IDLE.
- IDLE:
  - phy_tx_started -> PRIME.
  - phy_tx_done in IDLE is ignored.
- PRIME:
  - Go to STREAM when data_count >= start_threshold, or when (done_seen or phy_tx_done this cycle) and FIFO not empty.
  - If done is seen and the FIFO is empty, go to IDLE with no pulse_stream_end (empty packet).
  - start_threshold=0 with an empty FIFO does not enter STREAM until the FIFO is non-empty.
- STREAM, on each strobe:
  - FIFO not empty: pop and output the sample.
  - FIFO empty and done not seen: underrun. Output 0, pulse_underrun=1, underrun_count increments and saturates at 16'hFFFF.
  - FIFO empty and done seen: no output that strobe. Go to TAIL with tail counter = tail_len; if tail_len==0, go to IDLE and fire pulse_stream_end.
  - A phy_tx_done arriving in the same cycle as the empty strobe counts as done seen (no underrun).
- TAIL:
  - Each strobe outputs zero with dac_iq_valid=1 and decrements the counter.
  - When the counter reaches 0 on a strobe, go to IDLE with pulse_stream_end in the same cycle.
- phy_tx_started while not IDLE is ignored; the current packet continues.
- tx_stream_active is registered with the state: it rises the cycle after phy_tx_started and falls with the IDLE entry.
- Inputs are sampled each cycle. A strobe and a start pulse in the same cycle in IDLE produce no output.

Optional Feature:
- Macro TX_IQ_STREAMER_HOLD_LAST_EN.
- Defined: an underrun sample repeats the last popped sample. A register holds the last sample; it clears to 0 on IDLE entry and on rst. Tail samples remain zero.
- Undefined: underrun samples are zero and the last-sample register is not built.

Test Plan:
- Normal packet: threshold=4, tail_len=3. PHY writes 10 samples A0..A9, then done; strobe every 4 clk. Required: streaming starts once count>=4; dac_iq shows A0..A9 in order, each 1 cycle after its strobe; then 3 zero valids; pulse_stream_end on the 3rd tail strobe; underrun_count=0.
- Underrun: threshold=2; write 2 samples, stall 3 strobes, then write 2 more and done. Required: 3 zero outputs, pulse_underrun x3, underrun_count=3. With TX_IQ_STREAMER_HOLD_LAST_EN, those 3 outputs equal the 2nd sample.
- Early done in PRIME: threshold=100; write 5 samples, then done. Required: STREAM entered the cycle of done; all 5 samples output.
- Empty packet: phy_tx_started, then phy_tx_done, no writes. Required: back to IDLE; no dac_iq_valid and no pulse_stream_end; tx_stream_active high only between the two pulses.
- Reset mid-STREAM after 3 samples: rst high 1 cycle. Required: the next cycle shows IDLE, rden=0, dac_iq=0, underrun_count=0, tx_stream_active=0; a new phy_tx_started streams normally.
- Saturation and edge cases: force 65540 underruns -> count holds 16'hFFFF. tail_len=0 -> pulse_stream_end on the first empty-after-done strobe.
